// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed-display common scanner.
//
// Each digit owns a slot of PRESCALE clocks. The first BLANK_CYCLES of a slot are
// dead time (BLANK). The rest of the slot is DRIVE, where the common of the current
// digit is asserted if that digit is enabled. At each slot end the selection moves
// to the next enabled digit. Disabled digits are skipped entirely.
//
// Optional feature: define DIGIT_SCAN_DIMMING_EN to add the Bright port. Bright
// shortens the DRIVE window. With the macro undefined, the full window is always used.
//
// Parameters
//   NUM_DIGITS     number of commons (2..16)
//   PRESCALE       clocks per digit slot (2..65535)
//   BLANK_CYCLES   dead-time clocks at slot start (0..PRESCALE-1)
//   COM_ACTIVE_LOW 1: asserted common is driven 0, 0: asserted common is driven 1
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   ScanEn     1 = scan runs, 0 = idle with all commons inactive
//   DigitMask  per-digit enable
//   Bright     brightness 0..15 (only with DIGIT_SCAN_DIMMING_EN)
//   ComOut     registered one-hot common drive
//   DigitSel   registered current digit index, for the segment mux
//   FrameTick  registered one-cycle pulse when the selection wraps

module digit_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned COM_ACTIVE_LOW = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ScanEn,
  input  logic [NUM_DIGITS-1:0]         DigitMask,
`ifdef DIGIT_SCAN_DIMMING_EN
  input  logic [3:0]                    Bright,
`endif
  output logic [NUM_DIGITS-1:0]         ComOut,
  output logic [$clog2(NUM_DIGITS)-1:0] DigitSel,
  output logic                          FrameTick
);

  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] COM_OFF   = (COM_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_d;
  logic             tick_d;
  logic             slot_start;
  logic [NUM_DIGITS-1:0] com_d;

  logic             adv_found, start_found;
  logic [SEL_W-1:0] adv_idx, start_idx;
  logic             in_window;

  // Index base+off reduced modulo NUM_DIGITS (off never exceeds NUM_DIGITS).
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                input int unsigned     off);
    int unsigned t;
    t = 32'(base) + off;
    if (t >= NUM_DIGITS) t = t - NUM_DIGITS;
    return SEL_W'(t);
  endfunction

  // Candidate digits. adv_idx is the next enabled digit strictly after DigitSel,
  // or DigitSel itself when it is the only enabled digit. start_idx is the first
  // enabled digit at or after DigitSel. The loops run downward so the nearest
  // candidate is the one that sticks.
  always_comb begin
    adv_found   = 1'b0;
    adv_idx     = DigitSel;
    start_found = 1'b0;
    start_idx   = DigitSel;
    for (int k = int'(NUM_DIGITS); k >= 1; k--) begin
      if (DigitMask[wrap_idx(DigitSel, unsigned'(k))]) begin
        adv_found = 1'b1;
        adv_idx   = wrap_idx(DigitSel, unsigned'(k));
      end
    end
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      if (DigitMask[wrap_idx(DigitSel, unsigned'(k))]) begin
        start_found = 1'b1;
        start_idx   = wrap_idx(DigitSel, unsigned'(k));
      end
    end
  end

  // Next state, slot counter, selection and frame pulse.
  // BLANK and DRIVE follow directly from the next count value. With
  // BLANK_CYCLES=0, a slot is therefore DRIVE from its first cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    sel_d      = DigitSel;
    tick_d     = 1'b0;
    slot_start = 1'b0;
    if (!ScanEn) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          slot_start = 1'b1;
          if (start_found) sel_d = start_idx;
        end
        S_BLANK, S_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            slot_start = 1'b1;
            if (adv_found) begin
              sel_d  = adv_idx;
              tick_d = (adv_idx <= DigitSel);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
      state_d = (cnt_d < CNT_BLANK) ? S_BLANK : S_DRIVE;
    end
  end

`ifdef DIGIT_SCAN_DIMMING_EN
  logic [3:0]  bright_q;
  logic [3:0]  bright_use;
  int unsigned win_lim;

  // Brightness is latched at slot start. The value on the port is used directly
  // on that first cycle, so a slot with no blank time gets the new level at once.
  always_comb begin
    bright_use = slot_start ? Bright : bright_q;
    win_lim    = BLANK_CYCLES +
                 (((PRESCALE - BLANK_CYCLES) * (32'(bright_use) + 32'd1)) >> 4);
    in_window  = (32'(cnt_d) < win_lim);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             bright_q <= 4'd0;
    else if (slot_start) bright_q <= Bright;
  end
`else
  assign in_window = 1'b1;
`endif

  // Common drive. At most one bit is ever set. It is gated by the live mask
  // bit, so clearing the current digit drops its common on the next edge.
  always_comb begin
    com_d = COM_OFF;
    if ((state_d == S_DRIVE) && DigitMask[sel_d] && in_window)
      com_d = COM_OFF ^ (NUM_DIGITS'(1) << sel_d);
  end

  // State register and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      DigitSel  <= '0;
      FrameTick <= 1'b0;
      ComOut    <= COM_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      DigitSel  <= sel_d;
      FrameTick <= tick_d;
      ComOut    <= com_d;
    end
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of display commons (legal range 2..16).
REQ-002 Parameter PRESCALE, default 1000, clock cycles per digit slot (legal range 2..65535).
REQ-003 Parameter BLANK_CYCLES, default 2, dead-time cycles at the start of each slot (0 <= BLANK_CYCLES < PRESCALE).
REQ-004 Parameter COM_ACTIVE_LOW, default 1; 1 = asserted common driven 0, 0 = asserted common driven 1.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 ScanEn  input  1  1 = scanning runs, 0 = idle with all commons inactive.
REQ-008 DigitMask  input  NUM_DIGITS  bit i = 1 means digit i takes part in the scan.
REQ-009 Bright  input  4  brightness level 0..15 (present only with DIMMING_EN).
REQ-010 ComOut  output  NUM_DIGITS  registered one-hot common drive, polarity per COM_ACTIVE_LOW.
REQ-011 DigitSel  output  clog2(NUM_DIGITS)  registered index of the current digit, for the segment mux.
REQ-012 FrameTick  output  1  registered one-cycle pulse at each frame wrap.

Function
REQ-013 State machine SHALL have states IDLE, BLANK and DRIVE.
- IDLE -> BLANK when ScanEn=1.
- BLANK -> DRIVE when the slot counter reaches BLANK_CYCLES.
- DRIVE -> BLANK at slot end.
- Any state -> IDLE when ScanEn=0.
REQ-014 Slot counter SHALL count 0..PRESCALE-1 in BLANK/DRIVE; slot end is count==PRESCALE-1; next cycle count=0.
REQ-015 Only in DRIVE with DigitMask[DigitSel]=1 SHALL ComOut bit DigitSel be asserted; all other bits SHALL be inactive.
REQ-016 At slot end DigitSel SHALL advance to the next index above it (mod NUM_DIGITS) whose DigitMask bit is 1, wrapping past NUM_DIGITS-1 to 0.
REQ-017 FrameTick SHALL pulse for 1 cycle at a slot end where the advance wraps (new index <= old index), including a single enabled digit re-selecting itself.
REQ-018 If DigitMask is all zero, DigitSel SHALL hold, ComOut SHALL stay inactive, FrameTick SHALL stay 0, and slot timing SHALL continue.
REQ-019 Clearing DigitMask[DigitSel] mid-slot SHALL deassert its common on the next edge; the mask SHALL otherwise affect selection only at slot end.
REQ-020 ScanEn 1->0 SHALL on the next edge enter IDLE, make ComOut inactive, clear the slot counter and hold DigitSel.
REQ-021 ScanEn 0->1 SHALL start a new slot in BLANK at the first enabled index >= DigitSel (wrapping); first assertion SHALL follow BLANK_CYCLES+1 edges later.
REQ-022 ComOut SHALL never have more than one bit asserted, including on the cycle of any transition.

Reset
REQ-023 While RST=1: state=IDLE, slot counter=0, DigitSel=0, FrameTick=0, ComOut all inactive (all ones if COM_ACTIVE_LOW=1).
REQ-024 Reset asserted mid-slot SHALL force reset values immediately, independent of CLK.
REQ-025 After RST deasserts, the first state change SHALL occur on the first rising CLK edge.

Configuration
REQ-026 Macro DIGIT_SCAN_DIMMING_EN SHALL control dimming.
- Defined: Bright is a port and is sampled at slot start. DRIVE SHALL assert the common only while count < BLANK_CYCLES + ((PRESCALE-BLANK_CYCLES)*(Bright+1))>>4. Bright=15 gives the full window; a result of zero cycles means no assertion in that slot.
- Undefined: Bright port is absent and the full DRIVE window is always used.

Verification (NUM_DIGITS=8, PRESCALE=4, BLANK_CYCLES=1, COM_ACTIVE_LOW=1)
REQ-027 Reset release, ScanEn=1, DigitMask=8'hFF -> ComOut=8'hFE on cycles 2-4. DigitSel then steps 0,1,...,7,0 every 4 cycles. FrameTick pulses once per 32 cycles.
REQ-028 DigitMask=8'b1000_0101 -> DigitSel sequence 0,2,7,0. Only 3 slots per frame. FrameTick at each 7->0 advance.
REQ-029 DigitMask=8'h00 for 40 cycles -> ComOut=8'hFF throughout, FrameTick=0, DigitSel constant.
REQ-030 ScanEn dropped during DigitSel=3 DRIVE -> ComOut=8'hFF next edge. Re-enable -> 1 blank cycle, then ComOut=8'hF7.
REQ-031 RST pulsed asynchronously mid-DRIVE (between edges) -> ComOut=8'hFF and DigitSel=0 before the next CLK edge.
REQ-032 DIMMING_EN with PRESCALE=17, BLANK_CYCLES=1, Bright=7 -> common asserted for 8 of 17 cycles per slot; Bright=15 -> 16 cycles.
